// File: rtl/snake_occ_map_mp_pkg.sv
// Shared types and constants for the multi-player snake occupancy map.
// Coordinates travel as packed {x,y} words of XYW bits.
package snake_pkg;

    localparam int XW  = 6;
    localparam int YW  = 5;
    localparam int XYW = XW + YW;

    localparam int CELL_EMPTY = 0;
    localparam int CLEAR_ALL  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } sweep_state_t;

    function automatic logic [XYW-1:0] xy_pack(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {x, y};
    endfunction

    function automatic logic [XW-1:0] xy_x(input logic [XYW-1:0] xy);
        return xy[XYW-1:YW];
    endfunction

    function automatic logic [YW-1:0] xy_y(input logic [XYW-1:0] xy);
        return xy[YW-1:0];
    endfunction

endpackage

// File: rtl/snake_occ_map_mp_if.sv
// Bundle between game controller / renderer (master) and the occupancy map (slave).
interface snake_occ_map_mp_if #(
    parameter int NP  = 2,
    parameter int IDW = 3
);
    import snake_pkg::*;

    logic                tick;
    logic [NP-1:0]       alive;
    logic [NP-1:0]       eat;
    logic [NP*XYW-1:0]   head_xy;
    logic [NP*XYW-1:0]   tail_xy;
    logic [NP*XYW-1:0]   next_xy;
    logic [XW-1:0]       q_x;
    logic [YW-1:0]       q_y;
    logic [IDW-1:0]      q_owner;
    logic                body_on;
    logic [NP-1:0]       hit;
    logic                clear_req;
    logic [IDW-1:0]      clear_id;
    logic                busy;
    logic                clear_done;
    logic                tick_err;

    modport master (
        output tick, alive, eat, head_xy, tail_xy, next_xy, q_x, q_y, clear_req, clear_id,
        input  q_owner, body_on, hit, busy, clear_done, tick_err
    );

    modport slave (
        input  tick, alive, eat, head_xy, tail_xy, next_xy, q_x, q_y, clear_req, clear_id,
        output q_owner, body_on, hit, busy, clear_done, tick_err
    );

endinterface

// File: rtl/snake_occ_map_mp_hit_check.sv
// Collision verdict for one player: occupied target (minus vacating tails),
// head-to-head on the same target, or moving onto another player's current head.
module snake_hit_check
    import snake_pkg::*;
#(
    parameter int NP  = 2,
    parameter int IDW = 3,
    parameter int IDX = 0
) (
    input  logic              tick_ok_i,
    input  logic [NP-1:0]     alive_i,
    input  logic [NP-1:0]     eat_i,
    input  logic [NP*XYW-1:0] head_xy_i,
    input  logic [NP*XYW-1:0] tail_xy_i,
    input  logic [NP*XYW-1:0] next_xy_i,
    input  logic [IDW-1:0]    owner_next_i,
    output logic              hit_o
);

    logic [XYW-1:0] my_next;
    logic           tail_vacant;
    logic           next_clash;
    logic           head_clash;

    assign my_next = next_xy_i[IDX*XYW +: XYW];

    // A popping tail frees its cell this tick, including this player's own tail.
    always_comb begin
        tail_vacant = 1'b0;
        next_clash  = 1'b0;
        head_clash  = 1'b0;
        for (int j = 0; j < NP; j++) begin
            if (alive_i[j] && !eat_i[j] && (tail_xy_i[j*XYW +: XYW] == my_next))
                tail_vacant = 1'b1;
            if ((j != IDX) && alive_i[j]) begin
                if (next_xy_i[j*XYW +: XYW] == my_next)
                    next_clash = 1'b1;
                if (head_xy_i[j*XYW +: XYW] == my_next)
                    head_clash = 1'b1;
            end
        end
    end

    assign hit_o = tick_ok_i && alive_i[IDX] &&
                   (((owner_next_i != IDW'(CELL_EMPTY)) && !tail_vacant) || next_clash || head_clash);

endmodule

// File: rtl/snake_occ_map_mp.sv
// Occupancy map: per-cell owner codes, tick-time head/tail writes, per-player
// collision verdicts and a one-row-per-cycle clear sweep.
module snake_occ_map_mp
    import snake_pkg::*;
#(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int NP     = 2,
    parameter int IDW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    snake_occ_map_mp_if.slave  bus
);

    logic [IDW-1:0] map_q [GRID_H][GRID_W];
    logic [IDW-1:0] map_d [GRID_H][GRID_W];

    sweep_state_t   state_q;
    logic [YW-1:0]  row_q;
    logic [IDW-1:0] clr_id_q;
    logic           busy_q;
    logic           done_q;

    logic           tick_ok;
    logic [NP-1:0]  hit_w;
    logic [IDW-1:0] q_owner_w;

    assign tick_ok = bus.tick && !busy_q;

    // Sweep and tick writes never overlap: ticks are only honoured while idle.
    always_comb begin
        map_d = map_q;
        if (state_q == ST_SWEEP) begin
            for (int c = 0; c < GRID_W; c++) begin
                if ((clr_id_q == IDW'(CLEAR_ALL)) || (map_q[row_q][c] == clr_id_q))
                    map_d[row_q][c] = IDW'(CELL_EMPTY);
            end
        end
        if (tick_ok) begin
            for (int i = 0; i < NP; i++) begin
                if (bus.alive[i] && !bus.eat[i])
                    map_d[xy_y(bus.tail_xy[i*XYW +: XYW])][xy_x(bus.tail_xy[i*XYW +: XYW])] = IDW'(CELL_EMPTY);
            end
            // Heads are written after all tail clears so they win on a shared cell.
            for (int i = 0; i < NP; i++) begin
                if (bus.alive[i])
                    map_d[xy_y(bus.head_xy[i*XYW +: XYW])][xy_x(bus.head_xy[i*XYW +: XYW])] = IDW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < GRID_H; r++)
                for (int c = 0; c < GRID_W; c++)
                    map_q[r][c] <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            clr_id_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        clr_id_q <= bus.clear_id;
                        row_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (row_q == YW'(GRID_H - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        row_q <= row_q + YW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NP; i++) begin : g_hit
        logic [XYW-1:0] next_xy;
        assign next_xy = bus.next_xy[i*XYW +: XYW];

        snake_hit_check #(
            .NP  (NP),
            .IDW (IDW),
            .IDX (i)
        ) u_hit (
            .tick_ok_i    (tick_ok),
            .alive_i      (bus.alive),
            .eat_i        (bus.eat),
            .head_xy_i    (bus.head_xy),
            .tail_xy_i    (bus.tail_xy),
            .next_xy_i    (bus.next_xy),
            .owner_next_i (map_q[xy_y(next_xy)][xy_x(next_xy)]),
            .hit_o        (hit_w[i])
        );
    end

    assign q_owner_w      = map_q[bus.q_y][bus.q_x];
    assign bus.q_owner    = q_owner_w;
    assign bus.body_on    = (q_owner_w != IDW'(CELL_EMPTY));
    assign bus.hit        = hit_w;
    assign bus.busy       = busy_q;
    assign bus.clear_done = done_q;
    assign bus.tick_err   = bus.tick && busy_q;

endmodule

// File: tb/tb_snake_occ_map_mp.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a grid-array model.
module tb_snake_occ_map_mp;
    import snake_pkg::*;

    localparam int NP  = 2;
    localparam int IDW = 3;
    localparam int GW  = 40;
    localparam int GH  = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snake_occ_map_mp_if #(.NP(NP), .IDW(IDW)) bus ();

    snake_occ_map_mp #(.GRID_W(GW), .GRID_H(GH), .NP(NP), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int mmap [GH][GW];
    int sweep_k = 0;
    int sw_id   = 0;

    int hx[NP], hy[NP], tx[NP], ty[NP], nx[NP], ny[NP];
    bit al[NP], ea[NP];
    bit tk, cr;
    int cid, qx, qy;

    int last_hit, last_q, last_err, last_busy, last_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            bus.head_xy[i*XYW +: XYW] = xy_pack(XW'(hx[i]), YW'(hy[i]));
            bus.tail_xy[i*XYW +: XYW] = xy_pack(XW'(tx[i]), YW'(ty[i]));
            bus.next_xy[i*XYW +: XYW] = xy_pack(XW'(nx[i]), YW'(ny[i]));
            bus.alive[i] = al[i];
            bus.eat[i]   = ea[i];
        end
        bus.tick      = tk;
        bus.clear_req = cr;
        bus.clear_id  = IDW'(cid);
        bus.q_x       = XW'(qx);
        bus.q_y       = YW'(qy);
    endtask

    task automatic model_reset();
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                mmap[r][c] = 0;
        sweep_k = 0;
        sw_id   = 0;
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int old;
        bit tick_ok;
        logic [NP-1:0] eh;
        drive();
        @(negedge clk);
        tick_ok = tk && (sweep_k == 0);
        eh = '0;
        for (int i = 0; i < NP; i++) begin
            if (tick_ok && al[i]) begin
                bit vac;
                bit hb;
                vac = 1'b0;
                hb  = 1'b0;
                for (int j = 0; j < NP; j++)
                    if (al[j] && !ea[j] && tx[j] == nx[i] && ty[j] == ny[i]) vac = 1'b1;
                if (mmap[ny[i]][nx[i]] != 0 && !vac) hb = 1'b1;
                for (int j = 0; j < NP; j++)
                    if (j != i && al[j] &&
                        ((nx[j] == nx[i] && ny[j] == ny[i]) || (hx[j] == nx[i] && hy[j] == ny[i])))
                        hb = 1'b1;
                eh[i] = hb;
            end
        end
        chk("hit", int'(bus.hit), int'(eh));
        chk("busy", int'(bus.busy), int'(sweep_k > 0));
        chk("clear_done", int'(bus.clear_done), int'(sweep_k == GH + 1));
        chk("tick_err", int'(bus.tick_err), int'(tk && sweep_k > 0));
        chk("q_owner", int'(bus.q_owner), mmap[qy][qx]);
        chk("body_on", int'(bus.body_on), int'(mmap[qy][qx] != 0));
        last_hit  = int'(bus.hit);
        last_q    = int'(bus.q_owner);
        last_err  = int'(bus.tick_err);
        last_busy = int'(bus.busy);
        last_done = int'(bus.clear_done);
        @(posedge clk);
        old = sweep_k;
        if (tk && old == 0) begin
            for (int j = 0; j < NP; j++)
                if (al[j] && !ea[j]) mmap[ty[j]][tx[j]] = 0;
            for (int j = 0; j < NP; j++)
                if (al[j]) mmap[hy[j]][hx[j]] = j + 1;
        end
        if (old >= 1 && old <= GH)
            for (int c = 0; c < GW; c++)
                if (sw_id == 0 || mmap[old-1][c] == sw_id) mmap[old-1][c] = 0;
        if (old == 0 && cr) begin
            sweep_k = 1;
            sw_id   = cid;
        end else if (old == GH + 1) begin
            sweep_k = 0;
        end else if (old > 0) begin
            sweep_k = old + 1;
        end
        #1;
    endtask

    task automatic idle();
        tk = 1'b0;
        cr = 1'b0;
    endtask

    task automatic peek(input string name, input int x, input int y, input int exp);
        idle();
        qx = x;
        qy = y;
        cycle();
        chk(name, last_q, exp);
    endtask

    task automatic scan();
        idle();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                qx = x;
                qy = y;
                cycle();
            end
    endtask

    task automatic wait_idle();
        idle();
        cycle();
        for (int k = 0; k < 60 && last_busy != 0; k++) cycle();
        chk("idle_timeout", last_busy, 0);
    endtask

    task automatic set_p(input int i, input int h_x, input int h_y, input int t_x, input int t_y,
                         input int n_x, input int n_y, input bit a, input bit e);
        hx[i] = h_x; hy[i] = h_y; tx[i] = t_x; ty[i] = t_y;
        nx[i] = n_x; ny[i] = n_y; al[i] = a;  ea[i] = e;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, done_at, done_seen;
        reset = 1'b1;
        for (int i = 0; i < NP; i++) set_p(i, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle();
        cid = 0; qx = 0; qy = 0;
        drive();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        qx = 7; qy = 5;
        cycle();
        chk("rst_busy", last_busy, 0);
        chk("rst_done", last_done, 0);
        chk("rst_err", last_err, 0);
        chk("rst_hit", last_hit, 0);
        chk("rst_cell", last_q, 0);

        // Build P0 body (5,5),(6,5) then step head (7,5) toward (8,5)
        tk = 1'b1;
        set_p(1, 30, 25, 30, 25, 31, 25, 1'b0, 1'b0);
        set_p(0, 5, 5, 0, 0, 6, 5, 1'b1, 1'b1); cycle();
        set_p(0, 6, 5, 0, 0, 7, 5, 1'b1, 1'b1); cycle();
        set_p(0, 7, 5, 5, 5, 8, 5, 1'b1, 1'b0); cycle();
        chk("step_hit", last_hit, 0);
        peek("step_next_empty", 8, 5, 0);
        peek("step_head_written", 7, 5, 1);
        peek("step_tail_popped", 5, 5, 0);

        // Moving onto another player's popping tail vs. a growing tail
        tk = 1'b1;
        set_p(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        set_p(1, 20, 20, 0, 0, 21, 20, 1'b1, 1'b1); cycle();
        set_p(0, 8, 5, 6, 5, 20, 20, 1'b1, 1'b0);
        set_p(1, 21, 20, 20, 20, 22, 20, 1'b1, 1'b0); cycle();
        chk("tail_vacant_hit", last_hit, 0);
        set_p(0, 9, 5, 7, 5, 21, 20, 1'b1, 1'b0);
        set_p(1, 22, 20, 21, 20, 23, 20, 1'b1, 1'b1); cycle();
        chk("tail_growing_hit", last_hit, 1);

        // Head-to-head on the same target, then head swap
        set_p(0, 10, 5, 0, 0, 10, 10, 1'b1, 1'b1);
        set_p(1, 25, 20, 0, 0, 10, 10, 1'b1, 1'b1); cycle();
        chk("same_next_hit", last_hit, 3);
        set_p(0, 11, 5, 0, 0, 26, 20, 1'b1, 1'b1);
        set_p(1, 26, 20, 0, 0, 11, 5, 1'b1, 1'b1); cycle();
        chk("swap_hit", last_hit, 3);

        // Clear player 1 only
        idle();
        cr = 1'b1; cid = 1; cycle();
        cr = 1'b0;
        nb = 0; done_at = -1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (last_busy != 0) nb++;
            if (last_done != 0) done_at = k;
        end
        chk("busy_len", nb, GH + 1);
        chk("done_pos", done_at, GH);
        peek("clr1_code1_gone", 10, 5, 0);
        peek("clr1_code2_kept", 22, 20, 2);

        // Tick and clear_req during a sweep
        tk = 1'b1;
        set_p(0, 12, 12, 0, 0, 13, 12, 1'b1, 1'b1);
        set_p(1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0); cycle();
        idle();
        cr = 1'b1; cid = 2; cycle();
        cr = 1'b0; cycle(); cycle();
        tk = 1'b1;
        set_p(0, 1, 1, 0, 0, 15, 15, 1'b1, 1'b0);
        set_p(1, 2, 2, 0, 0, 15, 15, 1'b1, 1'b0); cycle();
        chk("busy_tick_err", last_err, 1);
        chk("busy_tick_hit", last_hit, 0);
        tk = 1'b0; cr = 1'b1; cid = 0; cycle();
        cr = 1'b0;
        wait_idle();
        peek("busy_tick_no_write", 1, 1, 0);
        peek("clr2_code2_gone", 22, 20, 0);
        peek("clr2_ignored_req", 12, 12, 1);
        scan();

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            tk = ($urandom_range(0, 1) == 1);
            cr = ($urandom_range(0, 39) == 0);
            cid = $urandom_range(0, NP);
            for (int i = 0; i < NP; i++) begin
                hx[i] = $urandom_range(0, 7);
                hy[i] = $urandom_range(0, 7);
                if (i > 0)
                    while (hx[i] == hx[0] && hy[i] == hy[0]) hx[i] = $urandom_range(0, 7);
                tx[i] = $urandom_range(0, 7);
                ty[i] = $urandom_range(0, 7);
                nx[i] = $urandom_range(0, 7);
                ny[i] = $urandom_range(0, 7);
                al[i] = ($urandom_range(0, 3) != 0);
                ea[i] = ($urandom_range(0, 2) == 0);
            end
            qx = $urandom_range(0, 9);
            qy = $urandom_range(0, 9);
            cycle();
        end
        wait_idle();
        scan();

        // Clear everything
        idle();
        cr = 1'b1; cid = 0; cycle();
        cr = 1'b0;
        wait_idle();
        peek("clr_all_cell", 12, 12, 0);
        scan();

        // Reset in the middle of a sweep at row 12
        tk = 1'b1;
        set_p(0, 3, 25, 0, 0, 5, 25, 1'b1, 1'b1);
        set_p(1, 4, 25, 0, 0, 6, 25, 1'b1, 1'b1); cycle();
        idle();
        cr = 1'b1; cid = 0; cycle();
        cr = 1'b0;
        qx = 3; qy = 25;
        repeat (12) cycle();
        chk("pre_reset_cell", last_q, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.clear_done), 0);
        chk("mid_rst_cell", int'(bus.q_owner), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (last_done != 0) done_seen++;
        end
        chk("no_done_after_reset", done_seen, 0);
        peek("post_reset_cell", 4, 25, 0);
        scan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
